ce_interval_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 15 +
 rtl/tick_mux.sv | 13 +
 rtl/ce_interval_timer.sv | 129 ++++++++++++
 tb/tb_ce_interval_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, tick-select constants and default widths for ce_interval_timer
package timer_pkg;

    localparam int W_DEF   = 16;
    localparam int EVW_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic TSEL_1US  = 1'b0;
    localparam logic TSEL_10US = 1'b1;

endpackage

// File: rtl/tick_mux.sv
// rtl/tick_mux.sv - selects the 1 us or 10 us enable strobe as the timer tick
module tick_mux
    import timer_pkg::*;
(
    input  logic tsel_q,
    input  logic ce1us,
    input  logic ce10us,
    output logic tick
);

    assign tick = (tsel_q == TSEL_10US) ? ce10us : ce1us;

endmodule

// File: rtl/ce_interval_timer.sv
// rtl/ce_interval_timer.sv - one-shot/periodic interval timer on external tick strobes; CE_TIMER_IRQ_EN adds sticky irq
module ce_interval_timer
    import timer_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int EVW = EVW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce1us,
    input  logic           ce10us,
    input  logic           start,
    input  logic           stop,
    input  logic [W-1:0]   period,
    input  logic           periodic,
    input  logic           tsel,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   remain,
    output logic [EVW-1:0] ev_cnt
`ifdef CE_TIMER_IRQ_EN
    ,
    input  logic           irq_clr,
    output logic           irq
`endif
);

    state_t         state_q, state_d;
    logic [W-1:0]   period_q, period_d;
    logic           periodic_q, periodic_d;
    logic           tsel_q, tsel_d;
    logic [W-1:0]   remain_d;
    logic           done_d;
    logic [EVW-1:0] ev_cnt_d;
    logic           tick;
    logic           load;

    tick_mux u_tick_mux (
        .tsel_q (tsel_q),
        .ce1us  (ce1us),
        .ce10us (ce10us),
        .tick   (tick)
    );

    // A zero period never starts or restarts the timer.
    assign load = start && (period != '0);

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        tsel_d     = tsel_q;
        remain_d   = remain;
        done_d     = 1'b0;
        ev_cnt_d   = ev_cnt;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = RUN;
                    period_d   = period;
                    periodic_d = periodic;
                    tsel_d     = tsel;
                    remain_d   = period;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    remain_d = '0;
                end else if (load) begin
                    period_d   = period;
                    periodic_d = periodic;
                    tsel_d     = tsel;
                    remain_d   = period;
                end else if (tick) begin
                    if (remain > W'(1)) begin
                        remain_d = remain - W'(1);
                    end else begin
                        done_d   = 1'b1;
                        ev_cnt_d = ev_cnt + EVW'(1);
                        if (periodic_q) begin
                            remain_d = period_q;
                        end else begin
                            remain_d = '0;
                            state_d  = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tsel_q     <= TSEL_1US;
            remain     <= '0;
            done       <= 1'b0;
            ev_cnt     <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            tsel_q     <= tsel_d;
            remain     <= remain_d;
            done       <= done_d;
            ev_cnt     <= ev_cnt_d;
        end
    end

    assign busy = (state_q == RUN);

`ifdef CE_TIMER_IRQ_EN
    // Set from the visible done pulse so a clear in that same cycle loses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ce_interval_timer.sv
// tb/tb_ce_interval_timer.sv - self-checking bench for ce_interval_timer
module tb_ce_interval_timer;

    logic        clk = 1'b0;
    logic        rst_n, ce1us, ce10us, start, stop, periodic, tsel;
    logic [15:0] period;
    logic        busy, done;
    logic [15:0] remain;
    logic [7:0]  ev_cnt;
`ifdef CE_TIMER_IRQ_EN
    logic        irq_clr, irq;
`endif

    int checks = 0;
    int errors = 0;
    int gcnt   = 0;

    always #5 clk = ~clk;

    ce_interval_timer #(.W(16), .EVW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce1us   (ce1us),
        .ce10us  (ce10us),
        .start   (start),
        .stop    (stop),
        .period  (period),
        .periodic(periodic),
        .tsel    (tsel),
        .busy    (busy),
        .done    (done),
        .remain  (remain),
        .ev_cnt  (ev_cnt)
`ifdef CE_TIMER_IRQ_EN
        ,
        .irq_clr (irq_clr),
        .irq     (irq)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: counts ticks upward since the last load.
    bit         m_run, m_per, m_tsel, m_t, e_done, e_irq;
    int         m_n, m_cnt;
    logic [7:0] e_ev;

    function automatic int exp_remain();
        return m_run ? (m_n - m_cnt) : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_per = 0; m_tsel = 0; m_n = 0; m_cnt = 0;
            e_done = 0; e_ev = 0; e_irq = 0;
        end else begin
`ifdef CE_TIMER_IRQ_EN
            e_irq = e_done ? 1'b1 : (irq_clr ? 1'b0 : e_irq);
`endif
            m_t    = m_tsel ? ce10us : ce1us;
            e_done = 0;
            if (m_run && stop) begin
                m_run = 0;
            end else if (start && period != 0) begin
                m_run = 1; m_n = int'(period); m_per = periodic; m_tsel = tsel; m_cnt = 0;
            end else if (m_run && m_t) begin
                m_cnt++;
                if (m_cnt == m_n) begin
                    e_done = 1;
                    e_ev++;
                    if (m_per) m_cnt = 0;
                    else m_run = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("busy", busy, m_run);
            chk("done", done, e_done);
            chk("remain", remain, exp_remain());
            chk("ev_cnt", ev_cnt, e_ev);
`ifdef CE_TIMER_IRQ_EN
            chk("irq", irq, e_irq);
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
        gcnt++;
        start  = 0;
        stop   = 0;
        ce1us  = (gcnt % 5 == 0);
        ce10us = (gcnt % 50 == 0);
`ifdef CE_TIMER_IRQ_EN
        irq_clr = 0;
`endif
    endtask

    task automatic launch(input logic [15:0] p, input logic ts, input logic per);
        cyc();
        start = 1; period = p; tsel = ts; periodic = per;
    endtask

    int  n_t, nd, t1, t2, ev0, clr_pend;
    bit  found;

    initial begin
        rst_n = 0; start = 0; stop = 0; period = 0; periodic = 0; tsel = 0;
        ce1us = 0; ce10us = 0;
`ifdef CE_TIMER_IRQ_EN
        irq_clr = 0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_remain", remain, 0);
        chk("rst_ev", ev_cnt, 0);
        rst_n = 1;

        // One-shot, 3 ticks of 1 us.
        launch(16'd3, 1'b0, 1'b0);
        cyc();
        chk("t1_busy", busy, 1);
        chk("t1_remain", remain, 3);
        n_t = int'(ce1us); found = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (done) begin found = 1; break; end
            n_t += int'(ce1us);
        end
        chk("t1_done_seen", found, 1);
        chk("t1_ticks", n_t, 3);
        chk("t1_busy_end", busy, 0);
        chk("t1_remain_end", remain, 0);
        chk("t1_ev", ev_cnt, 1);

        // Periodic, 2 ticks of 10 us.
        launch(16'd2, 1'b1, 1'b1);
        nd = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 250; i++) begin
            cyc();
            if (done) begin
                nd++;
                if (nd == 1) t1 = gcnt;
                if (nd == 2) begin t2 = gcnt; chk("t2_ev", ev_cnt, 3); end
            end
        end
        chk("t2_two_expiries", nd >= 2, 1);
        chk("t2_spacing", t2 - t1, 100);
        chk("t2_busy", busy, 1);
        cyc(); stop = 1;
        cyc();
        chk("t2_stopped", busy, 0);

        // Stop coincident with a tick at remain == 2.
        launch(16'd5, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (ce1us && exp_remain() == 2) begin stop = 1; found = 1; break; end
        end
        chk("t3_reached", found, 1);
        ev0 = int'(e_ev);
        cyc();
        chk("t3_busy", busy, 0);
        chk("t3_remain", remain, 0);
        chk("t3_done", done, 0);
        chk("t3_ev", ev_cnt, ev0);

        // Zero period ignored; restart over a final tick.
        launch(16'd0, 1'b0, 1'b0);
        cyc();
        chk("t4_zero_busy", busy, 0);
        chk("t4_zero_remain", remain, 0);
        launch(16'd3, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (ce1us && exp_remain() == 1) begin start = 1; period = 4; found = 1; break; end
        end
        chk("t4_reached", found, 1);
        cyc();
        chk("t4_remain", remain, 4);
        chk("t4_done", done, 0);
        chk("t4_busy", busy, 1);
        stop = 1;
        cyc();

        // Asynchronous reset mid-count.
        launch(16'd7, 1'b0, 1'b0);
        cyc();
        chk("t6_remain", remain, 7);
        #2 rst_n = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_remain0", remain, 0);
        chk("t6_done", done, 0);
        chk("t6_ev", ev_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done) nd++;
        end
        chk("t6_no_done", nd, 0);
        chk("t6_idle", busy, 0);

        // Period 1 periodic: 256 expiries wrap ev_cnt.
        launch(16'd1, 1'b0, 1'b1);
        nd = 0; clr_pend = 0; found = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
`ifdef CE_TIMER_IRQ_EN
            if (clr_pend == 1) begin irq_clr = 1; clr_pend = 2; end
            else if (clr_pend == 2) begin chk("t5_irq_cleared", irq, 0); clr_pend = 0; end
            else if (clr_pend == 3) begin chk("t5_irq_kept", irq, 1); clr_pend = 0; end
`endif
            if (done) begin
                nd++;
                if (nd == 255) chk("t5_ev255", ev_cnt, 255);
`ifdef CE_TIMER_IRQ_EN
                if (nd == 10) begin irq_clr = 1; clr_pend = 3; end
                if (nd == 20) clr_pend = 1;
`endif
                if (nd == 256) begin found = 1; break; end
            end
        end
        chk("t5_reached", found, 1);
        chk("t5_ev_wrap", ev_cnt, 0);
        cyc(); stop = 1;
        cyc();
        chk("t5_stopped", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
